stage_execute_mc: RTL

Parametrised execute stage with an EX/MEM pipeline register. Adds an iterative multi-cycle multiply/divide unit beside the single-cycle ALU. Operands are selected by forwarding, branch/jump resolution drives ex_pc_src/ex_pc_target, and results are registered into the MEM stage. A stall output freezes upstream stages while a mul/div runs. During the stall the stage inserts bubbles into MEM.

---
 rtl/exec_pkg.sv | 46 ++++
 rtl/muldiv_iter.sv | 98 +++++++++
 rtl/stage_execute_mc.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, forwarding selects,
// branch condition types and the mul/div sequencer states.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_MUL   = 4'd8,
    ALU_MULHU = 4'd9,
    ALU_DIVU  = 4'd10,
    ALU_REMU  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [2:0] {
    COND_EQ  = 3'd0,
    COND_NE  = 3'd1,
    COND_LT  = 3'd4,
    COND_GE  = 3'd5,
    COND_LTU = 3'd6,
    COND_GEU = 3'd7
  } cond_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // Ops 8..11 are handled by the iterative unit.
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// op[1] selects divide, op[0] selects the upper half (mulhu) or remainder (remu).
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  muldiv_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [1:0]      op_q, op_d;

  logic [XLEN:0] add_sum, rem_shift, rem_diff;

  // hi:lo is the product accumulator for mul, remainder:quotient for div.
  assign add_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
  assign rem_shift = {hi_q, lo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, opnd_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = '0;
          op_d    = op;
          hi_d    = '0;
          lo_d    = op[1] ? a : b;
          opnd_d  = op[1] ? b : a;
        end
      end
      BUSY: begin
        if (op_q[1]) begin
          if (!rem_diff[XLEN]) begin
            hi_d = rem_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = rem_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          {hi_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign busy   = (state_q == BUSY);
  assign done   = (state_q == DONE);
  assign result = op_q[0] ? hi_q : lo_q;

endmodule

// File: rtl/stage_execute_mc.sv
// Execute stage: operand forwarding, ALU, branch resolution, iterative mul/div
// with upstream stall, and the EX/MEM pipeline register.
module stage_execute_mc
  import exec_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          MULDIV_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_clear,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_write,
  input  logic                  ex_jump,
  input  logic                  ex_jump_cond,
  input  logic [2:0]            ex_jump_cond_type,
  input  logic [3:0]            ex_alu_control,
  input  logic                  ex_alu_src_op1,
  input  logic                  ex_alu_src_op2,
  input  logic [1:0]            ex_result_src,
  input  logic [XLEN-1:0]       ex_pc,
  input  logic [XLEN-1:0]       ex_pc_plus_4,
  input  logic [XLEN-1:0]       ex_imm_ext,
  input  logic [XLEN-1:0]       ex_rd1,
  input  logic [XLEN-1:0]       ex_rd2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       wb_result,
  input  logic [1:0]            ex_op1_forward,
  input  logic [1:0]            ex_op2_forward,
  output logic                  mem_reg_write,
  output logic                  mem_mem_write,
  output logic [1:0]            mem_result_src,
  output logic [XLEN-1:0]       mem_alu_result,
  output logic [XLEN-1:0]       mem_write_data,
  output logic [XLEN-1:0]       mem_pc_plus_4,
  output logic [XLEN-1:0]       mem_imm_ext,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  ex_pc_src,
  output logic [XLEN-1:0]       ex_pc_target,
  output logic                  ex_stall
);

  localparam int unsigned SH_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [XLEN-1:0] rs1_val, rs2_val, op1, op2, alu_result, md_result;
  logic [XLEN:0]   cmp_diff;
  logic            flag_z, flag_n, flag_c, flag_v, cond_true;
  logic            is_md, md_start, md_busy, md_done;

  always_comb begin
    rs1_val = ex_rd1;
    rs2_val = ex_rd2;
    case (fwd_sel_e'(ex_op1_forward))
      FWD_WB:  rs1_val = wb_result;
      FWD_MEM: rs1_val = mem_alu_result;
      default: rs1_val = ex_rd1;
    endcase
    case (fwd_sel_e'(ex_op2_forward))
      FWD_WB:  rs2_val = wb_result;
      FWD_MEM: rs2_val = mem_alu_result;
      default: rs2_val = ex_rd2;
    endcase
  end

  assign op1 = ex_alu_src_op1 ? rs1_val : '0;
  assign op2 = ex_alu_src_op2 ? ex_imm_ext : rs2_val;

  // Branch flags come from forwarded rs1 - rs2; C means no borrow.
  assign cmp_diff = {1'b0, rs1_val} - {1'b0, rs2_val};
  assign flag_z   = (cmp_diff[XLEN-1:0] == '0);
  assign flag_n   = cmp_diff[XLEN-1];
  assign flag_c   = ~cmp_diff[XLEN];
  assign flag_v   = (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]) & (cmp_diff[XLEN-1] ^ rs1_val[XLEN-1]);

  always_comb begin
    cond_true = 1'b0;
    case (cond_type_e'(ex_jump_cond_type))
      COND_EQ:  cond_true = flag_z;
      COND_NE:  cond_true = ~flag_z;
      COND_LT:  cond_true = flag_n ^ flag_v;
      COND_GE:  cond_true = ~(flag_n ^ flag_v);
      COND_LTU: cond_true = ~flag_c;
      COND_GEU: cond_true = flag_c;
      default:  cond_true = 1'b0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(ex_alu_control))
      ALU_ADD: alu_result = op1 + op2;
      ALU_SUB: alu_result = op1 - op2;
      ALU_AND: alu_result = op1 & op2;
      ALU_OR:  alu_result = op1 | op2;
      ALU_XOR: alu_result = op1 ^ op2;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLL: alu_result = op1 << op2[SH_W-1:0];
      ALU_SRL: alu_result = op1 >> op2[SH_W-1:0];
      ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: alu_result = md_result;
      default: alu_result = '0;
    endcase
  end

  // Issue only from idle; reset and flush suppress a new start.
  assign is_md    = is_muldiv(ex_alu_control);
  assign md_start = MULDIV_EN & reset & ex_valid & is_md & ~mem_clear & ~md_busy & ~md_done;
  assign ex_stall = md_start | md_busy;

  generate
    if (MULDIV_EN) begin : g_md
      muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .clear  (mem_clear),
        .start  (md_start),
        .op     (ex_alu_control[1:0]),
        .a      (op1),
        .b      (op2),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
      );
    end else begin : g_no_md
      assign md_busy   = 1'b0;
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  assign ex_pc_src    = reset & ex_valid & (ex_jump | (ex_jump_cond & cond_true)) & ~ex_stall;
  assign ex_pc_target = ex_pc + ex_imm_ext;

  // EX/MEM register: flush, invalid slot or stall all load a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_result_src <= '0;
      mem_alu_result <= '0;
      mem_write_data <= '0;
      mem_pc_plus_4  <= '0;
      mem_imm_ext    <= '0;
      mem_rd         <= '0;
    end else if (mem_clear || !ex_valid || ex_stall) begin
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_result_src <= '0;
      mem_alu_result <= '0;
      mem_write_data <= '0;
      mem_pc_plus_4  <= '0;
      mem_imm_ext    <= '0;
      mem_rd         <= '0;
    end else begin
      mem_reg_write  <= ex_reg_write;
      mem_mem_write  <= ex_mem_write;
      mem_result_src <= ex_result_src;
      mem_alu_result <= alu_result;
      mem_write_data <= rs2_val;
      mem_pc_plus_4  <= ex_pc_plus_4;
      mem_imm_ext    <= ex_imm_ext;
      mem_rd         <= ex_rd;
    end
  end

endmodule
